// File: rtl/rr_rotate_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The release strobe is named rel because "release" is a reserved word.
interface rr_rotate_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   req;
    logic                 rel;
    logic [NUM_REQ-1:0]   grant;
    logic                 grant_vld;
    logic [IDX_WIDTH-1:0] grant_idx;
    logic                 timeout;

    // Requester side
    modport master (output req, rel, input grant, grant_vld, grant_idx, timeout);
    // Arbiter side
    modport slave  (input req, rel, output grant, grant_vld, grant_idx, timeout);
endinterface

// File: rtl/rr_rotate_arbiter.sv
// Round-robin arbiter: rotate requests so the priority pointer sits at bit 0,
// priority-encode, rotate the winner back. The grant is held until release,
// the owner dropping its request, or an optional hold timeout.
module rr_rotate_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int IDX_WIDTH  = $clog2(NUM_REQ),
    parameter int MAX_HOLD   = 0,
    parameter int HOLD_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    rr_rotate_arbiter_if.slave bus
);
    typedef enum logic {IDLE, OWNED} state_t;

    localparam logic [IDX_WIDTH:0]    NREQ_W = (IDX_WIDTH+1)'(NUM_REQ);
    localparam logic [HOLD_WIDTH-1:0] HOLD_W = HOLD_WIDTH'(MAX_HOLD);
    localparam logic [HOLD_WIDTH-1:0] ONE_W  = HOLD_WIDTH'(1);

    state_t               state, state_nx;
    logic [IDX_WIDTH-1:0] ptr, ptr_nx, arb_ptr, own_next, win_off, win_idx;
    logic [IDX_WIDTH-1:0] idx_q, idx_nx;
    logic [NUM_REQ-1:0]   arb_req, rot_req, win_grant, grant_q, grant_nx;
    logic [HOLD_WIDTH-1:0] hold_cnt, hold_nx;
    logic                 win_found, vld_q, vld_nx, to_q, to_nx;
    logic                 hold_hit, end_grant;

    // Index add modulo NUM_REQ; both operands are < NUM_REQ so one subtract wraps.
    function automatic logic [IDX_WIDTH-1:0] wrap_add(input logic [IDX_WIDTH-1:0] a,
                                                      input logic [IDX_WIDTH-1:0] b);
        logic [IDX_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= NREQ_W) s = s - NREQ_W;
        return s[IDX_WIDTH-1:0];
    endfunction

    assign own_next  = wrap_add(idx_q, IDX_WIDTH'(1));
    assign hold_hit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_W);
    // grant_q is one-hot on idx_q, so this is req[grant_idx] without a variable index
    assign end_grant = bus.rel | ~(|(bus.req & grant_q)) | hold_hit;

    // In OWNED the candidate pool excludes the current owner and starts after it
    always_comb begin
        arb_ptr = ptr;
        arb_req = bus.req;
        if (state == OWNED) begin
            arb_ptr = own_next;
            arb_req = bus.req & ~grant_q;
        end
    end

    // Rotate, priority-encode lowest set bit, rotate the winner back
    always_comb begin
        rot_req   = '0;
        win_found = 1'b0;
        win_off   = '0;
        win_grant = '0;
        for (int i = 0; i < NUM_REQ; i++)
            for (int j = 0; j < NUM_REQ; j++)
                if (wrap_add(IDX_WIDTH'(i), arb_ptr) == IDX_WIDTH'(j)) rot_req[i] = arb_req[j];
        for (int i = NUM_REQ-1; i >= 0; i--)
            if (rot_req[i]) begin
                win_found = 1'b1;
                win_off   = IDX_WIDTH'(i);
            end
        win_idx = wrap_add(win_off, arb_ptr);
        for (int i = 0; i < NUM_REQ; i++)
            win_grant[i] = win_found && (win_idx == IDX_WIDTH'(i));
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        grant_nx = grant_q;
        idx_nx   = idx_q;
        vld_nx   = vld_q;
        hold_nx  = hold_cnt;
        to_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant_nx = win_grant;
                    idx_nx   = win_idx;
                    vld_nx   = 1'b1;
                    hold_nx  = ONE_W;
                    state_nx = OWNED;
                end
            end
            OWNED: begin
                if (end_grant) begin
                    ptr_nx = own_next;
                    // release on the same edge wins over the timeout report
                    to_nx  = hold_hit & ~bus.rel;
                    if (win_found) begin
                        grant_nx = win_grant;
                        idx_nx   = win_idx;
                        hold_nx  = ONE_W;
                    end else begin
                        grant_nx = '0;
                        vld_nx   = 1'b0;
                        hold_nx  = '0;
                        state_nx = IDLE;
                    end
                end else begin
                    hold_nx = hold_cnt + ONE_W;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_q  <= '0;
            idx_q    <= '0;
            vld_q    <= 1'b0;
            hold_cnt <= '0;
            to_q     <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            grant_q  <= grant_nx;
            idx_q    <= idx_nx;
            vld_q    <= vld_nx;
            hold_cnt <= hold_nx;
            to_q     <= to_nx;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_vld = vld_q;
    assign bus.grant_idx = idx_q;
    assign bus.timeout   = to_q;
endmodule
